pong_match_ctrl: RTL

Parametrised match controller for the Pong game. It sits between the debounced button pulses, the ball engine and the score/overlay renderer. It sequences serve, play, point, pause and game-over phases, and keeps per-player scores with a configurable win rule. It drives ball enable/reset/serve direction and frame-based delays, replacing the single start/stop toggle.

---
 rtl/pong_match_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences serve/play/point/pause/over phases,
// keeps saturating per-player scores and drives the ball engine controls.
module pong_match_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int WIN_BY_TWO   = 0,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_enable,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         winner,
    output logic [2:0]         match_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] WIN_THR    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W:0]   LEAD_TWO   = (SCORE_W + 1)'(2);
    localparam bit                 DEUCE_EN   = (WIN_BY_TWO != 32'sd0);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (s == SCORE_MAX) begin
            sat_inc = s;
        end else begin
            sat_inc = s + SCORE_ONE;
        end
    endfunction

    // A score at the ceiling always wins, otherwise threshold plus optional two-point lead.
    function automatic logic has_won(input logic [SCORE_W-1:0] me,
                                     input logic [SCORE_W-1:0] opp);
        logic leads;
        leads   = ({1'b0, me} >= ({1'b0, opp} + LEAD_TWO));
        has_won = (me == SCORE_MAX) || ((me >= WIN_THR) && (!DEUCE_EN || leads));
    endfunction

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [SCORE_W-1:0] score_l_r, score_l_s, score_r_r, score_r_s;
    logic [1:0]         winner_r, winner_s;
    logic               serve_dir_r, serve_dir_s;
    logic               ball_enable_r, ball_reset_r;
    logic               ball_enable_s, ball_reset_s;

    // Next-state, counter, score and winner decisions for every phase.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        score_l_s   = score_l_r;
        score_r_s   = score_r_r;
        winner_s    = winner_r;
        serve_dir_s = serve_dir_r;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_s     = ST_SERVE;
                    cnt_s       = SERVE_LOAD;
                    score_l_s   = SCORE_ZERO;
                    score_r_s   = SCORE_ZERO;
                    winner_s    = 2'b00;
                    serve_dir_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_r <= CNT_ONE) begin
                        state_s = ST_PLAY;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_PLAY: begin
                // A miss outranks a simultaneous pause; a double miss is a dead ball.
                if (miss_left && miss_right) begin
                    state_s = ST_POINT;
                    cnt_s   = POINT_LOAD;
                end else if (miss_left) begin
                    score_r_s   = sat_inc(score_r_r);
                    serve_dir_s = 1'b0;
                    state_s     = ST_POINT;
                    cnt_s       = POINT_LOAD;
                end else if (miss_right) begin
                    score_l_s   = sat_inc(score_l_r);
                    serve_dir_s = 1'b1;
                    state_s     = ST_POINT;
                    cnt_s       = POINT_LOAD;
                end else if (pause) begin
                    state_s = ST_PAUSE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (cnt_r <= CNT_ONE) begin
                        cnt_s = CNT_ZERO;
                        if (has_won(score_l_r, score_r_r)) begin
                            state_s  = ST_OVER;
                            winner_s = 2'b01;
                        end else if (has_won(score_r_r, score_l_r)) begin
                            state_s  = ST_OVER;
                            winner_s = 2'b10;
                        end else begin
                            state_s = ST_SERVE;
                            cnt_s   = SERVE_LOAD;
                        end
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    state_s = ST_IDLE;
                end else if (pause) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = CNT_ZERO;
                score_l_s   = SCORE_ZERO;
                score_r_s   = SCORE_ZERO;
                winner_s    = 2'b00;
                serve_dir_s = 1'b0;
            end
        endcase
        ball_enable_s = (state_s == ST_PLAY);
        ball_reset_s  = (state_s == ST_IDLE) || (state_s == ST_SERVE) || (state_s == ST_OVER);
    end

    // State and registered output update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            score_l_r     <= SCORE_ZERO;
            score_r_r     <= SCORE_ZERO;
            winner_r      <= 2'b00;
            serve_dir_r   <= 1'b0;
            ball_enable_r <= 1'b0;
            ball_reset_r  <= 1'b1;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            score_l_r     <= score_l_s;
            score_r_r     <= score_r_s;
            winner_r      <= winner_s;
            serve_dir_r   <= serve_dir_s;
            ball_enable_r <= ball_enable_s;
            ball_reset_r  <= ball_reset_s;
        end
    end

    assign match_state = state_r;
    assign score_l     = score_l_r;
    assign score_r     = score_r_r;
    assign winner      = winner_r;
    assign serve_dir   = serve_dir_r;
    assign ball_enable = ball_enable_r;
    assign ball_reset  = ball_reset_r;

endmodule
